// File: rtl/xdma_pkg.sv
// Shared XDMA definitions: stream/descriptor widths, descriptor ctl bits, C2H FSM states.
package xdma_pkg;

  localparam int unsigned XDMA_DW    = 256;
  localparam int unsigned XDMA_KEEPW = XDMA_DW / 8;
  localparam int unsigned XDMA_LENW  = 28;

  // Descriptor ctl word bit positions
  localparam int unsigned CTL_STOP      = 0;
  localparam int unsigned CTL_COMPLETED = 1;
  localparam int unsigned CTL_EOP       = 4;

  // Default ctl word for a single self-contained stream descriptor (0x0013)
  localparam logic [15:0] XDMA_DSC_CTL = (16'(1) << CTL_STOP)
                                       | (16'(1) << CTL_COMPLETED)
                                       | (16'(1) << CTL_EOP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DESC = 2'd1,
    DATA = 2'd2
  } c2h_state_e;

endpackage

// File: rtl/xdma_keep_mask_gen.sv
// Final-beat byte-enable generator.
// Ports:
//   len_lsb  in   byte offset within a beat (len modulo KEEP_WIDTH)
//   keep     out  tkeep for the final beat; all-ones when len_lsb is 0
module xdma_keep_mask_gen
  import xdma_pkg::*;
#(
  parameter int unsigned KEEP_WIDTH = XDMA_KEEPW,
  localparam int unsigned OFF_W     = $clog2(KEEP_WIDTH)
) (
  input  logic [OFF_W-1:0]      len_lsb,
  output logic [KEEP_WIDTH-1:0] keep
);

  // A remainder of zero means the final beat is completely full.
  always_comb begin
    keep = '1;
    if (len_lsb != '0) begin
      keep = (KEEP_WIDTH'(1) << len_lsb) - KEEP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/xdma_c2h_stream_writer.sv
// Card-to-host stream writer: takes a (host address, byte length) request, issues one
// XDMA C2H descriptor-bypass load, then forwards the user payload onto s_axis_c2h with
// generated tkeep/tlast.
// Ports:
//   CLK, RST_N                 user clock, async active-low reset
//   req_valid/ready/addr/len   write request
//   data_valid/ready, data     user payload stream (pass-through in DATA state)
//   c2h_dsc_byp_*              descriptor bypass toward xdma_0 (load is combinational)
//   s_axis_c2h_*               AXIS master toward xdma_0 (combinational pass-through)
//   busy, done, xfer_cnt       status: not idle, completion/drop pulse, completed count
module xdma_c2h_stream_writer
  import xdma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XDMA_DW,
  parameter int unsigned LEN_WIDTH  = XDMA_LENW,
  parameter logic [15:0] DSC_CTL    = XDMA_DSC_CTL
) (
  input  logic                    CLK,
  input  logic                    RST_N,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,

  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [DATA_WIDTH-1:0]   data,

  input  logic                    c2h_dsc_byp_ready,
  output logic                    c2h_dsc_byp_load,
  output logic [63:0]             c2h_dsc_byp_src_addr,
  output logic [63:0]             c2h_dsc_byp_dst_addr,
  output logic [LEN_WIDTH-1:0]    c2h_dsc_byp_len,
  output logic [15:0]             c2h_dsc_byp_ctl,

  output logic                    s_axis_c2h_tvalid,
  input  logic                    s_axis_c2h_tready,
  output logic [DATA_WIDTH-1:0]   s_axis_c2h_tdata,
  output logic [DATA_WIDTH/8-1:0] s_axis_c2h_tkeep,
  output logic                    s_axis_c2h_tlast,

  output logic                    busy,
  output logic                    done,
  output logic [31:0]             xfer_cnt
);

  localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(KEEP_W);
  // One extra bit so that ceil(len/KEEP_W) never overflows.
  localparam int unsigned BEATS_W = LEN_WIDTH - OFF_W + 1;

  c2h_state_e state, state_next;

  logic                 req_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [31:0]          xfer_cnt_q;
  logic [63:0]          dst_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [15:0]          ctl_q;
  logic [KEEP_W-1:0]    last_keep_q;
  logic [BEATS_W-1:0]   beats_left_q;

  logic [KEEP_W-1:0]    last_keep_c;
  logic [BEATS_W-1:0]   beats_req_c;
  logic                 last_beat_c;
  logic                 accept_c;
  logic                 zero_len_c;
  logic                 beat_c;
  logic                 final_beat_c;

  xdma_keep_mask_gen #(
    .KEEP_WIDTH (KEEP_W)
  ) u_keep_mask (
    .len_lsb (req_len[OFF_W-1:0]),
    .keep    (last_keep_c)
  );

  // ceil(len / KEEP_W): whole beats plus one for any partial remainder.
  assign beats_req_c = BEATS_W'(req_len[LEN_WIDTH-1:OFF_W]) + BEATS_W'(|req_len[OFF_W-1:0]);
  assign last_beat_c = (beats_left_q == BEATS_W'(1));
  assign zero_len_c  = (req_len == '0);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake/stream outputs
  always_comb begin
    state_next        = state;
    accept_c          = 1'b0;
    beat_c            = 1'b0;
    final_beat_c      = 1'b0;
    c2h_dsc_byp_load  = 1'b0;
    s_axis_c2h_tvalid = 1'b0;
    s_axis_c2h_tkeep  = '0;
    s_axis_c2h_tlast  = 1'b0;
    data_ready        = 1'b0;
    case (state)
      IDLE: begin
        accept_c = req_valid & req_ready_q;
        if (accept_c && !zero_len_c) begin
          state_next = DESC;
        end
      end
      DESC: begin
        c2h_dsc_byp_load = c2h_dsc_byp_ready;
        if (c2h_dsc_byp_ready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        s_axis_c2h_tvalid = data_valid;
        data_ready        = s_axis_c2h_tready;
        s_axis_c2h_tlast  = last_beat_c;
        s_axis_c2h_tkeep  = last_beat_c ? last_keep_q : '1;
        beat_c            = data_valid & s_axis_c2h_tready;
        if (beat_c && last_beat_c) begin
          final_beat_c = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Descriptor fields, beat tracking and status registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      xfer_cnt_q   <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      ctl_q        <= '0;
      last_keep_q  <= '0;
      beats_left_q <= '0;
    end else begin
      req_ready_q <= (state_next == IDLE);
      busy_q      <= (state_next != IDLE);
      // A zero-length request is acknowledged and dropped with a done pulse.
      done_q      <= (accept_c && zero_len_c) || final_beat_c;
      if (final_beat_c) begin
        xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
      if (accept_c && !zero_len_c) begin
        dst_q        <= req_addr;
        len_q        <= req_len;
        ctl_q        <= DSC_CTL;
        last_keep_q  <= last_keep_c;
        beats_left_q <= beats_req_c;
      end else if (beat_c) begin
        beats_left_q <= beats_left_q - BEATS_W'(1);
      end
    end
  end

  assign req_ready            = req_ready_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign xfer_cnt             = xfer_cnt_q;
  assign c2h_dsc_byp_src_addr = '0;
  assign c2h_dsc_byp_dst_addr = dst_q;
  assign c2h_dsc_byp_len      = len_q;
  assign c2h_dsc_byp_ctl      = ctl_q;
  assign s_axis_c2h_tdata     = data;

endmodule

// File: tb/tb_xdma_c2h_stream_writer.sv
// Bench for xdma_c2h_stream_writer: table of single transfers plus reset-mid-transfer sequence.
module tb_xdma_c2h_stream_writer;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_addr;
  logic [27:0]  req_len;
  logic         data_valid;
  logic         data_ready;
  logic [255:0] data;
  logic         dsc_ready;
  logic         load;
  logic [63:0]  src_addr;
  logic [63:0]  dst_addr;
  logic [27:0]  dsc_len;
  logic [15:0]  dsc_ctl;
  logic         tvalid;
  logic         tready;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tlast;
  logic         busy;
  logic         done;
  logic [31:0]  xfer_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 CLK = ~CLK;

  xdma_c2h_stream_writer dut (
    .CLK                  (CLK),
    .RST_N                (RST_N),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_len              (req_len),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .data                 (data),
    .c2h_dsc_byp_ready    (dsc_ready),
    .c2h_dsc_byp_load     (load),
    .c2h_dsc_byp_src_addr (src_addr),
    .c2h_dsc_byp_dst_addr (dst_addr),
    .c2h_dsc_byp_len      (dsc_len),
    .c2h_dsc_byp_ctl      (dsc_ctl),
    .s_axis_c2h_tvalid    (tvalid),
    .s_axis_c2h_tready    (tready),
    .s_axis_c2h_tdata     (tdata),
    .s_axis_c2h_tkeep     (tkeep),
    .s_axis_c2h_tlast     (tlast),
    .busy                 (busy),
    .done                 (done),
    .xfer_cnt             (xfer_cnt)
  );

  typedef struct {
    logic [63:0] addr;
    logic [27:0] len;
    int          delay;
    bit          rnd;
    int          beats;
    logic [31:0] keep;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [255:0] pat(input int b, input logic [63:0] a);
    return {8{32'hC0DE0000 | 32'(b)}} ^ {4{a}};
  endfunction

  // One complete transfer; expectations come from the caller's vector.
  task automatic run_xfer(input logic [63:0] addr, input logic [27:0] len, input int delay,
                          input bit rnd, input int exp_beats, input logic [31:0] exp_keep);
    int  cyc;
    int  beats;
    bit  got_load;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    req_valid = 1'b1; req_addr = addr; req_len = len;
    dsc_ready = 1'b0; data_valid = 1'b0; tready = 1'b0;
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    tick();
    req_valid = 1'b0; req_addr = ~addr; req_len = 28'hABCDEF0;
    if (len == 28'd0) begin
      data_valid = 1'b1; dsc_ready = 1'b1; tready = 1'b1;
      #1;
      chk("zero_done", done, 1'b1);
      chk("zero_no_load", load, 1'b0);
      chk("zero_no_tvalid", tvalid, 1'b0);
      chk("zero_busy", busy, 1'b0);
      chk("zero_cnt", xfer_cnt, exp_cnt);
      tick();
      chk("zero_done_drop", done, 1'b0);
      chk("zero_no_load2", load, 1'b0);
      data_valid = 1'b0; dsc_ready = 1'b0; tready = 1'b0;
      return;
    end
    // Descriptor phase
    got_load = 1'b0;
    cyc = 0;
    while (!got_load && cyc < 50) begin
      dsc_ready = (cyc >= delay); data_valid = 1'b1; data = pat(0, addr); tready = 1'b1;
      #1;
      chk("load", load, dsc_ready);
      chk("desc_no_tvalid", tvalid, 1'b0);
      chk("desc_no_dready", data_ready, 1'b0);
      chk("desc_busy", busy, 1'b1);
      chk("dst_addr", dst_addr, addr);
      chk("dsc_len", dsc_len, len);
      chk("src_addr", src_addr, 64'd0);
      chk("dsc_ctl", dsc_ctl, 16'h0013);
      got_load = load;
      tick();
      cyc++;
    end
    chk("load_seen", got_load, 1'b1);
    // Data phase; descriptor ready stays high to catch a second load
    beats = 0;
    cyc = 0;
    while (beats < exp_beats && cyc < 400) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_valid = 1'b1; dsc_ready = 1'b1; data = pat(beats, addr);
      #1;
      chk("tvalid", tvalid, 1'b1);
      chk("data_ready", data_ready, tready);
      chk("tdata", tdata, pat(beats, addr));
      chk("no_reload", load, 1'b0);
      if (tready) begin
        chk("tkeep", tkeep, (beats == exp_beats - 1) ? exp_keep : 32'hFFFF_FFFF);
        chk("tlast", tlast, (beats == exp_beats - 1));
        beats++;
      end
      tick();
      cyc++;
    end
    chk("beat_count", beats, exp_beats);
    exp_cnt = exp_cnt + 32'd1;
    data_valid = 1'b1; tready = 1'b1; dsc_ready = 1'b1;
    #1;
    chk("done", done, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("idle_no_tvalid", tvalid, 1'b0);
    chk("idle_no_dready", data_ready, 1'b0);
    chk("xfer_cnt", xfer_cnt, exp_cnt);
    tick();
    chk("done_drop", done, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    data_valid = 1'b0; tready = 1'b0; dsc_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    data_valid = 1'b0; data = '0; dsc_ready = 1'b0; tready = 1'b0;

    vecs[0] = '{addr: 64'h1000_0000, len: 28'd64,  delay: 0, rnd: 1'b0, beats: 2,  keep: 32'hFFFF_FFFF};
    vecs[1] = '{addr: 64'h2000_0040, len: 28'd33,  delay: 0, rnd: 1'b0, beats: 2,  keep: 32'h0000_0001};
    vecs[2] = '{addr: 64'h0000_0001, len: 28'd1,   delay: 0, rnd: 1'b0, beats: 1,  keep: 32'h0000_0001};
    vecs[3] = '{addr: 64'hDEAD_BEEF_0000_0000, len: 28'd64, delay: 5, rnd: 1'b0, beats: 2, keep: 32'hFFFF_FFFF};
    vecs[4] = '{addr: 64'h3000_0000, len: 28'd320, delay: 0, rnd: 1'b1, beats: 10, keep: 32'hFFFF_FFFF};
    vecs[5] = '{addr: 64'h4000_0000, len: 28'd0,   delay: 0, rnd: 1'b0, beats: 0,  keep: 32'h0};
    vecs[6] = '{addr: 64'h5000_0000, len: 28'd95,  delay: 2, rnd: 1'b0, beats: 3,  keep: 32'h7FFF_FFFF};
    vecs[7] = '{addr: 64'h6000_0000, len: 28'd32,  delay: 0, rnd: 1'b0, beats: 1,  keep: 32'hFFFF_FFFF};

    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_load", load, 1'b0);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_xfer_cnt", xfer_cnt, 32'd0);
    chk("rst_dst", dst_addr, 64'd0);
    chk("rst_len", dsc_len, 28'd0);
    chk("rst_ctl", dsc_ctl, 16'd0);
    #21 RST_N = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i].addr, vecs[i].len, vecs[i].delay, vecs[i].rnd, vecs[i].beats, vecs[i].keep);
    end

    // Reset asserted during beat 3 of a 10-beat transfer
    req_valid = 1'b1; req_addr = 64'h7000_0000; req_len = 28'd320;
    #1;
    chk("mid_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0; dsc_ready = 1'b1;
    #1;
    chk("mid_load", load, 1'b1);
    tick();
    tready = 1'b1; data_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      data = pat(b, 64'h7000_0000);
      #1;
      chk("mid_beat_tvalid", tvalid, 1'b1);
      chk("mid_beat_tlast", tlast, 1'b0);
      tick();
    end
    data = pat(2, 64'h7000_0000);
    #1;
    chk("pre_rst_tvalid", tvalid, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("arst_tvalid", tvalid, 1'b0);
    chk("arst_tlast", tlast, 1'b0);
    chk("arst_load", load, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_dready", data_ready, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_xfer_cnt", xfer_cnt, 32'd0);
    exp_cnt = 32'd0;
    tick();
    tick();
    chk("rst_hold_done", done, 1'b0);
    data_valid = 1'b0; tready = 1'b0; dsc_ready = 1'b0;
    #2 RST_N = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_cnt", xfer_cnt, 32'd0);
    chk("post_rst_done", done, 1'b0);
    run_xfer(64'h0000_8000_0000_0020, 28'd32, 0, 1'b0, 1, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
